// File: rtl/mem_bus_arbiter.sv
// Memory-port arbiter that lets the CPU share one synchronous memory port with a
// video line-fetch DMA. Video bursts are interleaved with CPU accesses, and the CPU
// is stalled only after video has starved for STARVE_LIMIT cycles.
module mem_bus_arbiter #(
  parameter int VIDEO_BURST  = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDataWrite,
  input  logic        cpuWrite,
  input  logic        cpuStrobe,
  output logic        cpuWait,
  output logic [7:0]  cpuDataRead,
  input  logic        vidStart,
  input  logic [15:0] vidBase,
  output logic        vidBusy,
  output logic        vidValid,
  output logic [7:0]  vidIndex,
  output logic [7:0]  vidData,
  output logic [15:0] memAddr,
  output logic [7:0]  memDataWrite,
  output logic        memWrite,
  output logic        memStrobe,
  input  logic [7:0]  memDataRead
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [7:0] LAST_IDX   = 8'(VIDEO_BURST - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t      state;
  logic [15:0] ptr;
  logic [7:0]  cnt;
  logic [7:0]  starve;
  logic        vid_rd;    // a video read was strobed last cycle
  logic        cpu_rd;    // a CPU read was strobed last cycle
  logic [7:0]  vid_idx;
  logic [7:0]  hold;
  logic        vid_grant;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    vid_grant    = 1'b0;
    cpuWait      = 1'b0;
    memAddr      = cpuAddr;
    memDataWrite = cpuDataWrite;
    memWrite     = cpuWrite & cpuStrobe;
    memStrobe    = cpuStrobe;
    if (state == BURST) begin
      vid_grant = !cpuStrobe || (starve >= STARVE_MAX);
      cpuWait   = cpuStrobe && (starve >= STARVE_MAX);
    end
    if (vid_grant) begin
      memAddr   = ptr;
      memWrite  = 1'b0;
      memStrobe = 1'b1;
    end
  end

  assign vidBusy     = (state == BURST);
  assign vidValid    = vid_rd;
  assign vidIndex    = vid_idx;
  assign vidData     = vid_rd ? memDataRead : 8'h00;
  assign cpuDataRead = cpu_rd ? memDataRead : hold;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      starve  <= '0;
      vid_rd  <= 1'b0;
      cpu_rd  <= 1'b0;
      vid_idx <= '0;
      hold    <= '0;
    end else begin
      vid_rd <= vid_grant;
      cpu_rd <= cpuStrobe && !cpuWrite && !vid_grant;
      if (cpu_rd) hold <= memDataRead;
      if (vid_grant) vid_idx <= cnt;

      case (state)
        IDLE: begin
          if (vidStart) begin
            ptr    <= vidBase;
            cnt    <= '0;
            starve <= '0;
            state  <= BURST;
          end
        end
        BURST: begin
          // vidStart is deliberately not looked at here, including on the last grant.
          if (vid_grant) begin
            ptr    <= ptr + 16'd1;
            cnt    <= cnt + 8'd1;
            starve <= '0;
            if (cnt == LAST_IDX) state <= IDLE;
          end else begin
            starve <= starve + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a byte memory model, video and CPU
// scoreboards, and directed scenarios for bursts, starvation, wrap, write and reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDataWrite;
  logic        cpuWrite;
  logic        cpuStrobe;
  logic        cpuWait;
  logic [7:0]  cpuDataRead;
  logic        vidStart;
  logic [15:0] vidBase;
  logic        vidBusy;
  logic        vidValid;
  logic [7:0]  vidIndex;
  logic [7:0]  vidData;
  logic [15:0] memAddr;
  logic [7:0]  memDataWrite;
  logic        memWrite;
  logic        memStrobe;
  logic [7:0]  memDataRead = 8'h00;

  mem_bus_arbiter #(.VIDEO_BURST(8), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .cpuAddr(cpuAddr), .cpuDataWrite(cpuDataWrite), .cpuWrite(cpuWrite),
    .cpuStrobe(cpuStrobe), .cpuWait(cpuWait), .cpuDataRead(cpuDataRead),
    .vidStart(vidStart), .vidBase(vidBase), .vidBusy(vidBusy),
    .vidValid(vidValid), .vidIndex(vidIndex), .vidData(vidData),
    .memAddr(memAddr), .memDataWrite(memDataWrite), .memWrite(memWrite),
    .memStrobe(memStrobe), .memDataRead(memDataRead)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory as the DUT sees it, and the contents the bench expects.
  logic [7:0] mem     [65536];
  logic [7:0] exp_mem [65536];

  always @(posedge clk) begin
    if (memStrobe && memWrite)  mem[memAddr] <= memDataWrite;
    if (memStrobe && !memWrite) memDataRead  <= mem[memAddr];
  end

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] addr;
  } vexp_t;

  vexp_t       vid_q[$];
  logic [15:0] addr_q[$];
  logic [7:0]  cpu_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: pops scoreboards as the DUT grants and returns data.
  logic       cpu_pend = 1'b0;
  logic [7:0] last_cpu = 8'h00;
  int         last_valid_cyc = 0;
  int         valid_seen = 0;

  always @(negedge clk) begin
    if (!reset) begin
      cpu_pend = 1'b0;
    end else begin
      if (cpu_pend) begin
        last_cpu = cpu_q.pop_front();
        check("cpu_rd_data", cpuDataRead, last_cpu);
        cpu_pend = 1'b0;
      end
      if (vidBusy && memStrobe && (cpuWait || !cpuStrobe)) begin
        if (addr_q.size() == 0) check("vid_grant_unexpected", memAddr, 16'hxxxx);
        else check("vid_addr", memAddr, addr_q.pop_front());
      end else if (cpuStrobe && !cpuWrite) begin
        cpu_q.push_back(exp_mem[cpuAddr]);
        cpu_pend = 1'b1;
      end
      if (vidValid) begin
        vexp_t e;
        valid_seen++;
        last_valid_cyc = cyc;
        if (vid_q.size() == 0) begin
          check("vid_valid_unexpected", vidIndex, 8'hxx);
        end else begin
          e = vid_q.pop_front();
          check("vid_index", vidIndex, e.idx);
          check("vid_data", vidData, exp_mem[e.addr]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [15:0] base);
    for (int k = 0; k < 8; k++) begin
      vexp_t e;
      e.idx  = 8'(k);
      e.addr = 16'(base + 16'(k));
      vid_q.push_back(e);
      addr_q.push_back(e.addr);
    end
  endtask

  task automatic wait_idle(input int budget, output int busy_cycles);
    int i;
    busy_cycles = 0;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (vidBusy) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
    if (i == budget) check("idle_timeout", vidBusy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int busy;
    int start_cyc;
    int bi;
    logic waited;

    reset = 1'b0;
    cpuAddr = '0; cpuDataWrite = '0; cpuWrite = 1'b0; cpuStrobe = 1'b0;
    vidStart = 1'b0; vidBase = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i ^ (i >> 8) ^ 8'h5C);
      exp_mem[i] = 8'(i ^ (i >> 8) ^ 8'h5C);
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", vidBusy, 1'b0);
    check("rst_valid", vidValid, 1'b0);
    check("rst_strobe", memStrobe, 1'b0);
    check("rst_write", memWrite, 1'b0);
    check("rst_wait", cpuWait, 1'b0);
    check("rst_index", vidIndex, 8'h00);
    check("rst_vdata", vidData, 8'h00);
    check("rst_cpudata", cpuDataRead, 8'h00);
    tick();
    reset = 1'b1;
    tick();

    // Uncontended burst from E010
    vidBase = 16'hE010; vidStart = 1'b1; start_cyc = cyc;
    push_burst(16'hE010);
    tick();
    vidStart = 1'b0;
    wait_idle(40, busy);
    check("burst_busy_cycles", busy, 8);
    check("burst_latency", last_valid_cyc - start_cyc, 9);
    check("burst_q_empty", vid_q.size() + addr_q.size(), 0);

    // Continuous CPU reads during a burst: C,C,C,V pattern
    cpuStrobe = 1'b1; cpuWrite = 1'b0; cpuAddr = 16'h0000;
    vidBase = 16'h4000; vidStart = 1'b1;
    push_burst(16'h4000);
    bi = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      waited = cpuWait;
      if (vidBusy) begin
        check("starve_pattern", cpuWait, (bi % 4) == 3);
        bi++;
      end else if (bi > 0) begin
        break;
      end
      @(posedge clk);
      #1;
      vidStart = 1'b0;
      if (!waited) cpuAddr = cpuAddr + 16'd1;
    end
    tick();
    cpuStrobe = 1'b0; vidStart = 1'b0;
    repeat (3) @(negedge clk);
    check("starve_busy_cycles", bi, 32);
    check("starve_q_empty", vid_q.size() + addr_q.size() + cpu_q.size(), 0);

    // Wrap from FFFE, vidStart while busy and on the last grant ignored
    tick();
    vidBase = 16'hFFFE; vidStart = 1'b1;
    push_burst(16'hFFFE);
    tick(); vidStart = 1'b0;
    tick();
    tick(); vidStart = 1'b1; vidBase = 16'h1234;
    tick(); vidStart = 1'b0;
    tick(); tick(); tick();
    tick(); vidStart = 1'b1; vidBase = 16'h1234;
    @(negedge clk);
    check("last_grant_busy", vidBusy, 1'b1);
    tick(); vidBase = 16'h2000;
    push_burst(16'h2000);
    @(negedge clk);
    check("idle_gap_busy", vidBusy, 1'b0);
    tick(); vidStart = 1'b0;
    wait_idle(40, busy);
    check("restart_busy_cycles", busy, 8);
    check("wrap_q_empty", vid_q.size() + addr_q.size(), 0);

    // CPU write into the burst window, then video reads it back
    tick();
    vidBase = 16'hE0FC; vidStart = 1'b1;
    push_burst(16'hE0FC);
    tick();
    vidStart = 1'b0;
    cpuStrobe = 1'b1; cpuWrite = 1'b1; cpuAddr = 16'hE100; cpuDataWrite = 8'h5A;
    exp_mem[16'hE100] = 8'h5A;
    @(negedge clk);
    check("wr_memwrite", memWrite, 1'b1);
    check("wr_memaddr", memAddr, 16'hE100);
    check("wr_memdata", memDataWrite, 8'h5A);
    check("wr_wait", cpuWait, 1'b0);
    tick();
    cpuStrobe = 1'b0; cpuWrite = 1'b0;
    @(negedge clk);
    check("wr_single_cycle", memWrite, 1'b0);
    @(negedge clk);
    check("wr_no_return", cpuDataRead, last_cpu);
    wait_idle(40, busy);
    check("wr_q_empty", vid_q.size() + addr_q.size(), 0);

    // Asynchronous reset in the middle of a burst
    tick();
    vidBase = 16'h3000; vidStart = 1'b1;
    push_burst(16'h3000);
    tick();
    vidStart = 1'b0;
    begin
      int i;
      for (i = 0; i < 20; i++) begin
        @(negedge clk);
        if (vidValid && vidIndex == 8'd3) break;
      end
      if (i == 20) check("idx3_timeout", vidIndex, 8'd3);
    end
    #2;
    reset = 1'b0;
    vid_q.delete();
    addr_q.delete();
    #1;
    check("async_busy", vidBusy, 1'b0);
    check("async_valid", vidValid, 1'b0);
    check("async_strobe", memStrobe, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    valid_seen = 0;
    repeat (20) @(negedge clk);
    check("post_reset_valid", valid_seen, 0);
    check("post_reset_busy", vidBusy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
